sequential_divider: RTL and testbench

//   Unsigned restoring shift-subtract divider; the inverse datapath of the sequential multiplier.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_if.sv | 38 +++
 rtl/step_down_counter.sv | 45 ++++
 rtl/sequential_divider.sv | 131 +++++++++++++
 tb/tb_sequential_divider.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared types and helpers for the sequential restoring divider.
//   - div_state_t : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   - step_width(): width of the iteration step counter for a given word length
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WORD_LENGTH = 8;

    // Counter only has to hold Word_Length-1 down to 0.
    function automatic int step_width(input int word_length);
        return $clog2(word_length);
    endfunction

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
//   Start/done handshake and operand/result bus of the sequential divider.
//   Signals:
//     start        request, sampled by the divider only while idle
//     dividend     numerator, captured on the accepting edge
//     divisor      denominator, captured on the accepting edge
//     busy         divider is running or presenting a result
//     done         single-cycle pulse, results valid from this cycle
//     quotient     last result, held until the next done
//     remainder    last result, held until the next done
//     div_by_zero  last request had a zero divisor
//   Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int Word_Length = div_pkg::DEFAULT_WORD_LENGTH
);

    logic                   start;
    logic [Word_Length-1:0] dividend;
    logic [Word_Length-1:0] divisor;
    logic                   busy;
    logic                   done;
    logic [Word_Length-1:0] quotient;
    logic [Word_Length-1:0] remainder;
    logic                   div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/step_down_counter.sv
// -----------------------------------------------------------------------------
// step_down_counter
//   Iteration counter for the divider. Loads Word_Length-1 and counts down by
//   one per enabled cycle; o_last flags the final iteration (count == 0).
//   Ports:
//     clk       rising-edge clock
//     reset     synchronous, active-low reset (clears the count)
//     i_load    load Word_Length-1
//     i_enable  decrement by one
//     o_last    count is zero
// -----------------------------------------------------------------------------
module step_down_counter
    import div_pkg::*;
#(
    parameter int Word_Length = DEFAULT_WORD_LENGTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_enable,
    output logic o_last
);

    localparam int              StepW   = step_width(Word_Length);
    localparam logic [StepW-1:0] StepTop = StepW'(Word_Length - 1);

    logic [StepW-1:0] r_step;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step <= '0;
        end else if (i_load) begin
            r_step <= StepTop;
        end else if (i_enable) begin
            // Wraps after the last iteration; harmless because the next
            // request reloads it before it is looked at again.
            r_step <= r_step - StepW'(1);
        end
    end

    assign o_last = (r_step == '0);

endmodule

// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
//   Unsigned restoring shift-subtract divider, one quotient bit per clock.
//   quotient = dividend / divisor, remainder = dividend % divisor.
//   A zero divisor completes immediately with quotient = all ones,
//   remainder = dividend and div_by_zero set.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low reset; aborts any division in flight
//     bus    div_if.slave: start/dividend/divisor in,
//            busy/done/quotient/remainder/div_by_zero out
//   Latency from the accepting edge: done follows edge Word_Length for a
//   normal division, edge 0 for a zero divisor.
// -----------------------------------------------------------------------------
module sequential_divider
    import div_pkg::*;
#(
    parameter int Word_Length = DEFAULT_WORD_LENGTH
) (
    input  logic       clk,
    input  logic       reset,
    div_if.slave       bus
);

    localparam int W = Word_Length;

    div_state_t     r_state;
    logic [W-1:0]   r_q;        // dividend shifting out, quotient shifting in
    logic [W:0]     r_r;        // partial remainder, one guard bit for the sign
    logic [W-1:0]   r_d;        // captured divisor
    logic [W-1:0]   r_quotient;
    logic [W-1:0]   r_remainder;
    logic           r_div_by_zero;
    logic           r_done;
    logic           r_busy;

    logic [W:0]     w_shift;
    logic [W:0]     w_trial;
    logic           w_negative;
    logic [W:0]     w_r_next;
    logic [W-1:0]   w_q_next;
    logic           w_accept;
    logic           w_last;

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor. A borrow (sign bit set) means the divisor
    // did not fit, so the shifted value is kept and a 0 quotient bit enters.
    assign w_shift    = {r_r[W-1:0], r_q[W-1]};
    assign w_trial    = w_shift - {1'b0, r_d};
    assign w_negative = w_trial[W];
    assign w_r_next   = w_negative ? w_shift : w_trial;
    assign w_q_next   = {r_q[W-2:0], ~w_negative};

    // Only a non-zero divisor enters RUN and therefore needs the counter.
    assign w_accept = (r_state == IDLE) && bus.start && (bus.divisor != '0);

    step_down_counter #(
        .Word_Length (W)
    ) u_step (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_enable (r_state == RUN),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the working registers are reset too, not just the FSM, so
            // an aborted division leaves no stale partial result behind.
            r_state       <= IDLE;
            r_q           <= '0;
            r_r           <= '0;
            r_d           <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= bus.dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_q     <= bus.dividend;
                            r_r     <= '0;
                            r_d     <= bus.divisor;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q <= w_q_next;
                    r_r <= w_r_next;
                    if (w_last) begin
                        // Remainder is always below the divisor, so the guard
                        // bit is zero here and can be dropped.
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_r_next[W-1:0];
                        r_div_by_zero <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_sequential_divider.sv
// -----------------------------------------------------------------------------
// tb_sequential_divider
//   Directed bench for sequential_divider with Word_Length = 8. Inputs are
//   driven 1 ns after a rising edge; outputs are looked at in the same slot,
//   well clear of the next edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sequential_divider;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    div_if #(.Word_Length(W)) bus ();

    sequential_divider #(.Word_Length(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in IDLE and verify latency, results and the
    // one-cycle done pulse. Leaves the divider back in IDLE.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_z, input int exp_lat, input string name);
        int n;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();                       // edge 0
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: done after edge %0d want edge %0d", name, n, exp_lat);
        end
        checks++;
        if (bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
            errors++;
            $display("FAIL %s result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     name, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_z);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
        checks++;
        if (bus.quotient !== exp_q || bus.remainder !== exp_r) begin
            errors++;
            $display("FAIL %s hold: got q=%0d r=%0d want q=%0d r=%0d",
                     name, bus.quotient, bus.remainder, exp_q, exp_r);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_div(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 8, "100/7");
        run_div(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8, "255/1");
        run_div(8'd0,   8'd9,   8'd0,   8'd0, 1'b0, 8, "0/9");
        run_div(8'd3,   8'd10,  8'd0,   8'd3, 1'b0, 8, "3/10");
        run_div(8'd200, 8'd200, 8'd1,   8'd0, 1'b0, 8, "200/200");
    endtask

    task automatic test_div_by_zero();
        run_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, "5/0");
        run_div(8'd9, 8'd3, 8'd3,  8'd0, 1'b0, 8, "9/3");
    endtask

    task automatic test_start_ignored();
        int n;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        tick();                       // edge 0
        bus.start = 1'b0;
        tick();
        tick();
        tick();                       // edge 3, step 4
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        bus.start    = 1'b1;
        tick();                       // edge 4
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd3 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL run_stable: got busy=%b done=%b q=%0d r=%0d want 1 0 3 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        n = 4;
        while (bus.done !== 1'b1 && n < 24) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignored_start: got edge=%0d q=%0d r=%0d want edge=8 q=14 r=2",
                     n, bus.quotient, bus.remainder);
        end
        // The ignored request must not be replayed afterwards.
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL not_queued: got %0d active cycles want 0", n);
        end
        run_div(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 8, "50/5");
    endtask

    task automatic test_reset_mid_run();
        int n;
        bus.dividend = 8'd77;
        bus.divisor  = 8'd4;
        bus.start    = 1'b1;
        tick();                       // edge 0
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // edge 4, step 3
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d active cycles want 0", n);
        end
        run_div(8'd77, 8'd4, 8'd19, 8'd1, 1'b0, 8, "77/4");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
